// File: rtl/rr_switch_allocator_4port.sv
// ============================================================================
// Module   : rr_switch_allocator_4port
// Purpose  : Registered round-robin switch allocator for a 4-port mesh router
//            (ports X1, X2, Y, LOCAL). Each output picks one requesting input
//            per cycle, scanning from its own round-robin pointer, and honours
//            downstream full. Grants and crossbar selects are registered, so
//            they appear one cycle after the request is sampled.
// Ports    : clk, rst          - clock, asynchronous active-high reset
//            en_i              - global allocate enable
//            req_valid_i[4]    - input i presents a flit
//            req_port_i[8]     - requested output of input i at [2i+1:2i]
//            req_last_i[4]     - flit is a packet tail (packet lock only)
//            out_full_i[4]     - downstream of output j cannot accept
//            in_grant_o[4]     - input i's flit consumed (registered pulse)
//            out_valid_o[4]    - output j carries a granted flit
//            out_sel_o[12]     - crossbar select of output j at [3j+2:3j]
//                                (0=STOP, 1=X1, 2=X2, 3=Y, 4=LOCAL)
// Options  : SA_PKT_LOCK_EN    - wormhole packet lock per output
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_switch_allocator_4port #(
    parameter int NPORT = 4,
    parameter int SELW  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic [NPORT-1:0]      req_valid_i,
    input  logic [2*NPORT-1:0]    req_port_i,
    input  logic [NPORT-1:0]      req_last_i,
    input  logic [NPORT-1:0]      out_full_i,
    output logic [NPORT-1:0]      in_grant_o,
    output logic [NPORT-1:0]      out_valid_o,
    output logic [SELW*NPORT-1:0] out_sel_o
);

    // Registered outputs and round-robin pointers
    logic [NPORT-1:0]      in_grant_q,  in_grant_d;
    logic [NPORT-1:0]      out_valid_q, out_valid_d;
    logic [SELW*NPORT-1:0] out_sel_q,   out_sel_d;
    logic [1:0]            ptr_q [NPORT];
    logic [1:0]            ptr_d [NPORT];

    // Per-output arbitration wires: w_cand[j][i] = input i requests output j
    logic [NPORT-1:0] w_cand [NPORT];
    logic [NPORT-1:0] w_elig [NPORT];
    logic [NPORT-1:0] w_hit;
    logic [NPORT-1:0] w_go;
    logic [1:0]       w_win  [NPORT];

`ifdef SA_PKT_LOCK_EN
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0] lock_q  [NPORT];
    logic [0:0] lock_d  [NPORT];
    logic [1:0] owner_q [NPORT];
    logic [1:0] owner_d [NPORT];
`else
    // Tail marker has no meaning when packets are not locked
    logic w_unused_last;
    assign w_unused_last = ^req_last_i;
`endif

    always_comb begin
        for (int j = 0; j < NPORT; j++) begin
            for (int i = 0; i < NPORT; i++) begin
                w_cand[j][i] = req_valid_i[i] && (req_port_i[2*i +: 2] == 2'(j));
            end
`ifdef SA_PKT_LOCK_EN
            // A locked output only listens to the packet that owns it
            w_elig[j] = (lock_q[j] == ST_LOCKED)
                      ? (w_cand[j] & (NPORT'(1) << owner_q[j]))
                      : w_cand[j];
`else
            w_elig[j] = w_cand[j];
`endif
        end
    end

    // First eligible input scanning upward from the pointer, modulo 4
    always_comb begin
        logic [1:0] idx;
        idx = '0;
        for (int j = 0; j < NPORT; j++) begin
            w_hit[j] = 1'b0;
            w_win[j] = ptr_q[j];
            for (int k = 0; k < NPORT; k++) begin
                idx = ptr_q[j] + 2'(k);
                if (!w_hit[j] && w_elig[j][idx]) begin
                    w_hit[j] = 1'b1;
                    w_win[j] = idx;
                end
            end
            w_go[j] = en_i && !out_full_i[j] && w_hit[j];
        end
    end

    always_comb begin
        in_grant_d  = '0;
        out_valid_d = '0;
        out_sel_d   = '0;
        for (int j = 0; j < NPORT; j++) begin
            ptr_d[j] = ptr_q[j];
`ifdef SA_PKT_LOCK_EN
            lock_d[j]  = lock_q[j];
            owner_d[j] = owner_q[j];
`endif
            if (w_go[j]) begin
                // Each input names one output, so grant bits never collide
                out_valid_d[j]              = 1'b1;
                out_sel_d[SELW*j +: SELW]   = SELW'(w_win[j]) + SELW'(1);
                in_grant_d[w_win[j]]        = 1'b1;
`ifdef SA_PKT_LOCK_EN
                if (req_last_i[w_win[j]]) begin
                    // Packet complete: release and move priority past the winner
                    lock_d[j] = ST_IDLE;
                    ptr_d[j]  = w_win[j] + 2'd1;
                end else begin
                    lock_d[j]  = ST_LOCKED;
                    owner_d[j] = w_win[j];
                end
`else
                ptr_d[j] = w_win[j] + 2'd1;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_grant_q  <= '0;
            out_valid_q <= '0;
            out_sel_q   <= '0;
            for (int j = 0; j < NPORT; j++) begin
                ptr_q[j] <= '0;
`ifdef SA_PKT_LOCK_EN
                lock_q[j]  <= ST_IDLE;
                owner_q[j] <= '0;
`endif
            end
        end else begin
            in_grant_q  <= in_grant_d;
            out_valid_q <= out_valid_d;
            out_sel_q   <= out_sel_d;
            for (int j = 0; j < NPORT; j++) begin
                ptr_q[j] <= ptr_d[j];
`ifdef SA_PKT_LOCK_EN
                lock_q[j]  <= lock_d[j];
                owner_q[j] <= owner_d[j];
`endif
            end
        end
    end

    assign in_grant_o  = in_grant_q;
    assign out_valid_o = out_valid_q;
    assign out_sel_o   = out_sel_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_switch_allocator_4port.sv
// ============================================================================
// Module   : tb_rr_switch_allocator_4port
// Purpose  : Self-checking bench for rr_switch_allocator_4port. A reference
//            model of the allocation rules predicts every cycle's outputs;
//            directed vectors add hand-computed literal expectations.
// Options  : SA_PKT_LOCK_EN selects the packet-lock expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_switch_allocator_4port;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [7:0]  req_port = '0;
    logic [3:0]  req_last = 4'b1111;
    logic [3:0]  out_full = '0;
    logic [3:0]  in_grant;
    logic [3:0]  out_valid;
    logic [11:0] out_sel;

    int n_chk  = 0;
    int n_pass = 0;

    rr_switch_allocator_4port dut (
        .clk         (clk),
        .rst         (rst),
        .en_i        (en),
        .req_valid_i (req_valid),
        .req_port_i  (req_port),
        .req_last_i  (req_last),
        .out_full_i  (out_full),
        .in_grant_o  (in_grant),
        .out_valid_o (out_valid),
        .out_sel_o   (out_sel)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: per output a priority start index, plus an optional
    // packet owner. Expected outputs are what the spec says the next edge
    // must register.
    // ------------------------------------------------------------------
    int          m_ptr [4];
    bit          m_lock[4];
    int          m_own [4];
    logic [3:0]  e_grant = '0;
    logic [3:0]  e_valid = '0;
    logic [11:0] e_sel   = '0;

    always @(posedge clk or posedge rst) begin
        int         np [4];
        bit         nl [4];
        int         no [4];
        logic [3:0] g, v;
        logic [11:0] s;
        int         win, i;
        if (rst) begin
            for (int j = 0; j < 4; j++) begin
                m_ptr[j]  <= 0;
                m_lock[j] <= 1'b0;
                m_own[j]  <= 0;
            end
            e_grant <= '0;
            e_valid <= '0;
            e_sel   <= '0;
        end else begin
            g = '0; v = '0; s = '0;
            for (int j = 0; j < 4; j++) begin
                np[j] = m_ptr[j]; nl[j] = m_lock[j]; no[j] = m_own[j];
                win = -1;
                if (en && !out_full[j]) begin
                    for (int k = 0; k < 4; k++) begin
                        i = (m_ptr[j] + k) % 4;
                        if (win < 0 && req_valid[i] && int'(req_port[2*i +: 2]) == j
`ifdef SA_PKT_LOCK_EN
                            && (!m_lock[j] || m_own[j] == i)
`endif
                           ) win = i;
                    end
                end
                if (win >= 0) begin
                    g[win] = 1'b1;
                    v[j] = 1'b1;
                    s[3*j +: 3] = 3'(win + 1);
`ifdef SA_PKT_LOCK_EN
                    if (req_last[win]) begin
                        nl[j] = 1'b0;
                        np[j] = (win + 1) % 4;
                    end else begin
                        nl[j] = 1'b1;
                        no[j] = win;
                    end
`else
                    np[j] = (win + 1) % 4;
`endif
                end
            end
            for (int j = 0; j < 4; j++) begin
                m_ptr[j]  <= np[j];
                m_lock[j] <= nl[j];
                m_own[j]  <= no[j];
            end
            e_grant <= g;
            e_valid <= v;
            e_sel   <= s;
        end
    end

    // Model comparison every cycle, away from the active edge
    always @(negedge clk) begin
        n_chk++;
        if ({in_grant, out_valid, out_sel} === {e_grant, e_valid, e_sel})
            n_pass++;
        else
            $display("FAIL model t=%0t: got grant=%b valid=%b sel=%h, want grant=%b valid=%b sel=%h",
                     $time, in_grant, out_valid, out_sel, e_grant, e_valid, e_sel);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] sels [$];
    logic [2:0] exp6 [4];
    int         y_n;
    bit         x2_on, x2_done;

    initial begin
`ifdef SA_PKT_LOCK_EN
        exp6[0] = 3'd3; exp6[1] = 3'd3; exp6[2] = 3'd3; exp6[3] = 3'd2;
`else
        exp6[0] = 3'd3; exp6[1] = 3'd2; exp6[2] = 3'd3; exp6[3] = 3'd3;
`endif
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_grant", 32'(in_grant), 32'h0);
        chk("reset_sel",   32'(out_sel),  32'h0);

        // X2 -> Y single request
        req_valid = 4'b0010; req_port = 8'b00_00_10_00;
        tick();
        chk("x2y_grant", 32'(in_grant),  32'b0010);
        chk("x2y_valid", 32'(out_valid), 32'b0100);
        chk("x2y_sel",   32'(out_sel),   32'h080);
        req_valid = '0;
        tick();
        chk("idle_valid", 32'(out_valid), 32'h0);

        // Y -> X1 blocked by downstream full, then released
        req_valid = 4'b0100; req_port = 8'h00; out_full = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("full_grant", 32'(in_grant),  32'h0);
            chk("full_valid", 32'(out_valid), 32'h0);
        end
        out_full = '0;
        tick();
        chk("release_grant", 32'(in_grant),    32'b0100);
        chk("release_sel",   32'(out_sel[2:0]), 32'd3);
        req_valid = '0;

        // Full permutation granted in one cycle
        req_valid = 4'b1111; req_port = 8'b10_11_00_01;
        tick();
        chk("perm_grant", 32'(in_grant),  32'hF);
        chk("perm_valid", 32'(out_valid), 32'hF);
        chk("perm_sel",   32'(out_sel),   32'b011_100_001_010);

        // Everybody to LOCAL, then reset in the middle of the traffic
        req_port = 8'hFF;
        repeat (3) tick();
        chk("traffic_valid", 32'(out_valid[3]), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_grant", 32'(in_grant),  32'h0);
        chk("async_valid", 32'(out_valid), 32'h0);
        chk("async_sel",   32'(out_sel),   32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Rotation on LOCAL starting from X1
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("rot_sel",   32'(out_sel[11:9]), 32'((k % 4) + 1));
            chk("rot_grant", 32'(in_grant),      32'(1 << (k % 4)));
        end
        en = 1'b0;
        tick();
        chk("en0_grant", 32'(in_grant), 32'h0);
        en = 1'b1;
        tick();
        chk("en1_sel", 32'(out_sel[11:9]), 32'd3);
        req_valid = '0;
        tick();

        // Y sends a 3-flit packet to X1, X2 joins after Y's first grant
        y_n = 0; x2_on = 1'b0; x2_done = 1'b0;
        req_port = 8'h00;
        for (int c = 0; c < 12 && (y_n < 3 || !x2_done); c++) begin
            req_valid[2] = (y_n < 3);
            req_last[2]  = (y_n == 2);
            req_valid[1] = x2_on && !x2_done;
            req_last[1]  = 1'b1;
            tick();
            if (out_valid[0]) sels.push_back(out_sel[2:0]);
            if (in_grant[2]) begin y_n++; x2_on = 1'b1; end
            if (in_grant[1]) x2_done = 1'b1;
        end
        req_valid = '0;
        req_last  = 4'b1111;
        chk("pkt_count", 32'(sels.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < sels.size()) chk("pkt_sel", 32'(sels[k]), 32'(exp6[k]));
        end
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
